// File: rtl/tc_product_rescaler.sv
// rtl/tc_product_rescaler.sv - two-stage round/shift/range rescaler for signed multiplier products
// Optional clamping of out-of-range results: define TC_RESCALE_SATURATE_EN (default build wraps).
module tc_product_rescaler #(
  parameter int IN_W  = 30,
  parameter int SHIFT = 14,
  parameter int OUT_W = 14
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [IN_W-1:0]  prod_in,
  input  logic             prod_vld,
  output logic             prod_rdy,
  output logic [OUT_W-1:0] res_out,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [15:0]      ovf_cnt
);

  localparam int SW = IN_W + 1 - SHIFT;
  localparam logic [IN_W:0]    HALF  = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    s1_vld_q, s1_vld_d;
  logic signed [IN_W:0]    s1_sum_q, s1_sum_d;
  logic                    s2_vld_q, s2_vld_d;
  logic [OUT_W-1:0]        res_q, res_d;
  logic [15:0]             ovf_q, ovf_d;

  logic                    s1_load;
  logic                    s2_load;
  logic signed [SW-1:0]    shifted;
  logic [SW-OUT_W:0]       upper;
  logic                    out_of_range;
  logic [OUT_W-1:0]        res_next;

  always_comb begin
    prod_rdy = !s1_vld_q || !s2_vld_q || res_rdy;
    s2_load  = s1_vld_q && (!s2_vld_q || res_rdy);
    s1_load  = !s1_vld_q || s2_load;

    // Bits above the result sign must all match the sign for the value to fit.
    shifted      = SW'(s1_sum_q >>> SHIFT);
    upper        = shifted[SW-1:OUT_W-1];
    out_of_range = !((&upper) || !(|upper));

`ifdef TC_RESCALE_SATURATE_EN
    res_next = out_of_range ? (shifted[SW-1] ? MIN_V : MAX_V) : shifted[OUT_W-1:0];
`else
    res_next = shifted[OUT_W-1:0];
`endif

    s1_vld_d = s1_vld_q;
    s1_sum_d = s1_sum_q;
    if (s1_load) begin
      s1_vld_d = prod_vld;
      s1_sum_d = {prod_in[IN_W-1], prod_in} + HALF;
    end

    s2_vld_d = s2_vld_q;
    res_d    = res_q;
    if (s2_load) begin
      s2_vld_d = 1'b1;
      res_d    = res_next;
    end else if (res_rdy) begin
      s2_vld_d = 1'b0;
    end

    ovf_d = ovf_q;
    if (s2_load && out_of_range && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_vld_q <= 1'b0;
      s1_sum_q <= '0;
      s2_vld_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_sum_q <= s1_sum_d;
      s2_vld_q <= s2_vld_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
    end
  end

  assign res_out = res_q;
  assign res_vld = s2_vld_q;
  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_tc_product_rescaler.sv
// tb/tb_tc_product_rescaler.sv - directed and randomized self-checking bench for tc_product_rescaler
module tb_tc_product_rescaler;

  localparam int IN_W  = 30;
  localparam int SHIFT = 14;
  localparam int OUT_W = 14;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic [IN_W-1:0]  prod_in = '0;
  logic             prod_vld = 1'b0;
  logic             prod_rdy;
  logic [OUT_W-1:0] res_out;
  logic             res_vld;
  logic             res_rdy = 1'b1;
  logic [15:0]      ovf_cnt;

  tc_product_rescaler #(.IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .prod_in (prod_in),
    .prod_vld(prod_vld),
    .prod_rdy(prod_rdy),
    .res_out (res_out),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .ovf_cnt (ovf_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  logic                    obs_vld, obs_prdy, in_xfer;
  logic signed [OUT_W-1:0] obs_out;
  logic [15:0]             obs_ovf;
  logic                    hold_chk = 1'b0;
  logic signed [OUT_W-1:0] hold_val = '0;
  longint                  sbq[$];
  longint                  ovf_exp = 0;
  int                      n_out = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint shifted_val(input logic [IN_W-1:0] d);
    longint x;
    x = longint'($signed(d));
    return (x + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
  endfunction

  function automatic bit is_oor(input logic [IN_W-1:0] d);
    longint r;
    r = shifted_val(d);
    return (r > (longint'(1) <<< (OUT_W - 1)) - 1) || (r < -(longint'(1) <<< (OUT_W - 1)));
  endfunction

  function automatic longint model(input logic [IN_W-1:0] d);
    longint r, maxv, minv;
    r    = shifted_val(d);
    maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
    minv = -(longint'(1) <<< (OUT_W - 1));
`ifdef TC_RESCALE_SATURATE_EN
    if (r > maxv) return maxv;
    if (r < minv) return minv;
    return r;
`else
    r = r & ((longint'(1) <<< OUT_W) - 1);
    if (r > maxv) r = r - (longint'(1) <<< OUT_W);
    return r;
`endif
  endfunction

  // One clock cycle: drive at negedge, sample settled outputs, score transfers at the coming posedge.
  task automatic tick(input logic vld, input logic [IN_W-1:0] d, input logic rdy, input logic rst);
    @(negedge ap_clk);
    prod_vld = vld;
    prod_in  = d;
    res_rdy  = rdy;
    ap_rst   = rst;
    #1;
    obs_vld  = res_vld;
    obs_out  = $signed(res_out);
    obs_prdy = prod_rdy;
    obs_ovf  = ovf_cnt;
    in_xfer  = 1'b0;
    if (!rst) begin
      if (hold_chk) begin
        chk("hold_vld", obs_vld, 1);
        chk("hold_out", obs_out, hold_val);
      end
      if (vld && obs_prdy) begin
        in_xfer = 1'b1;
        sbq.push_back(model(d));
        if (is_oor(d) && ovf_exp < 65535) ovf_exp++;
      end
      if (obs_vld && rdy) begin
        n_out++;
        if (sbq.size() == 0) chk("spurious_out", obs_out, 64'sd99999);
        else chk("order", obs_out, sbq.pop_front());
      end
      hold_chk = obs_vld && !rdy;
      hold_val = obs_out;
    end else begin
      sbq.delete();
      hold_chk = 1'b0;
      ovf_exp  = 0;
    end
    @(posedge ap_clk);
  endtask

  initial begin
    int idx;
    int sent;
    logic [IN_W-1:0] rd;

    // Reset state
    tick(0, '0, 1, 1);
    tick(0, '0, 1, 1);
    tick(0, '0, 1, 0);
    chk("rst_vld", obs_vld, 0);
    chk("rst_out", obs_out, 0);
    chk("rst_ovf", obs_ovf, 0);
    chk("rst_prdy", obs_prdy, 1);

    // Rounding, latency 2, back-to-back
    tick(1, 30'd16384, 1, 0);     chk("rnd_vld0", obs_vld, 0);
    tick(1, 30'd8192, 1, 0);      chk("rnd_vld1", obs_vld, 0);
    tick(1, 30'd8191, 1, 0);      chk("rnd_vld2", obs_vld, 1); chk("rnd_out0", obs_out, 1);
    tick(1, -30'sd8192, 1, 0);    chk("rnd_out1", obs_out, 1);
    tick(1, -30'sd8193, 1, 0);    chk("rnd_out2", obs_out, 0);
    tick(0, '0, 1, 0);            chk("rnd_out3", obs_out, 0);
    tick(0, '0, 1, 0);            chk("rnd_out4", obs_out, -1); chk("rnd_vld6", obs_vld, 1);
    tick(0, '0, 1, 0);            chk("rnd_empty", obs_vld, 0);

    // Overflow
    tick(1, 30'd536870911, 1, 0);
    tick(1, 30'h2000_0000, 1, 0);
    tick(0, '0, 1, 0);
`ifdef TC_RESCALE_SATURATE_EN
    chk("ovf_pos_out", obs_out, 8191);
`else
    chk("ovf_pos_out", obs_out, 0);
`endif
    chk("ovf_cnt1", obs_ovf, 1);
    tick(0, '0, 1, 0);
`ifdef TC_RESCALE_SATURATE_EN
    chk("ovf_neg_out", obs_out, -8192);
`else
    chk("ovf_neg_out", obs_out, 0);
`endif
    tick(0, '0, 1, 0);
    chk("ovf_cnt2", obs_ovf, 2);

    // Backpressure: stream 1..10, res_rdy low for stream cycles 3..7
    idx   = 1;
    n_out = 0;
    for (int k = 0; k < 60 && (idx <= 10 || sbq.size() != 0); k++) begin
      tick(idx <= 10, IN_W'(idx * 16384), !(k >= 3 && k <= 7), 0);
      if (k == 5) chk("bp_prdy_low", obs_prdy, 0);
      if (in_xfer) idx++;
    end
    chk("bp_sent", idx, 11);
    chk("bp_recv", n_out, 10);

    // Reset mid-stream with S1 and S2 full
    tick(1, IN_W'(5 * 16384), 0, 0);
    tick(1, IN_W'(6 * 16384), 0, 0);
    tick(1, IN_W'(7 * 16384), 0, 0);
    chk("mid_prdy_full", obs_prdy, 0);
    tick(0, '0, 0, 1);
    tick(0, '0, 1, 0);
    chk("mid_vld", obs_vld, 0);
    chk("mid_out", obs_out, 0);
    chk("mid_ovf", obs_ovf, 0);
    chk("mid_prdy", obs_prdy, 1);
    for (int k = 0; k < 4; k++) tick(0, '0, 1, 0);

    // Counter saturation
    for (int k = 0; k < 65540; k++) tick(1, 30'd536870911, 1, 0);
    for (int k = 0; k < 3; k++) tick(0, '0, 1, 0);
    chk("sat_cnt", obs_ovf, 65535);
    chk("sat_model", obs_ovf, ovf_exp);
    chk("sat_drain", sbq.size(), 0);

    // Random traffic against scoreboard
    tick(0, '0, 1, 1);
    sent = 0;
    for (int c = 0; c < 40000 && sent < 3000; c++) begin
      rd = IN_W'($urandom);
      if ($urandom_range(0, 1) == 1) rd = IN_W'($urandom_range(0, 1600000)) - IN_W'(800000);
      tick($urandom_range(0, 1) == 1, rd, $urandom_range(0, 1) == 1, 0);
      if (in_xfer) sent++;
    end
    for (int k = 0; k < 4; k++) tick(0, '0, 1, 0);
    chk("rand_sent", sent, 3000);
    chk("rand_drain", sbq.size(), 0);
    chk("rand_ovf", obs_ovf, ovf_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
